// File: rtl/scroll_scan_ctrl_pkg.sv
// seg_pkg: character codes, code type and scan FSM states shared by the display path.
package seg_pkg;
    typedef logic [3:0] char_t;
    localparam char_t CHAR_E    = 4'd10;
    localparam char_t CHAR_L    = 4'd11;
    localparam char_t CHAR_C    = 4'd12;
    localparam char_t CHAR_P    = 4'd13;
    localparam char_t CHAR_S    = 4'd14;
    localparam char_t CHAR_DASH = 4'd15;
    typedef enum logic [1:0] {IDLE, BLANK, SCAN} state_t;
endpackage

// File: rtl/scroll_scan_ctrl_tick_gen.sv
// tick_gen: free-running 0..DIV-1 counter, one-clock tick at terminal count while enabled.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] r_cnt;
    assign o_tick = i_en && (r_cnt == W'(DIV - 1));
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (o_tick)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/scroll_scan_ctrl.sv
// scroll_scan_ctrl: message buffer, digit scan sequencer and scroll offset for the sliding-text display.
module scroll_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_LEN    = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int SCROLL_DIV = 25000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_enable,
    input  logic                       i_pause,
    input  logic                       i_dir,
    input  logic                       i_msg_wr_en,
    input  logic [3:0]                 i_msg_wr_addr,
    input  char_t                      i_msg_wr_data,
    output char_t                      o_char_code,
    output logic [NUM_DIGITS-1:0]      o_an,
    output logic [$clog2(MSG_LEN)-1:0] o_scroll_pos,
    output logic                       o_wrap_pulse
);
    localparam int PW = $clog2(MSG_LEN);
    localparam int IW = PW + 1;
    localparam int DW = $clog2(NUM_DIGITS);
    state_t          r_state, w_state_nxt;
    logic [DW-1:0]   r_digit;
    logic [PW-1:0]   r_frame_off, r_pos, w_pos_nxt;
    logic [IW-1:0]   w_sum, w_rd_idx;
    char_t           r_buf [MSG_LEN];
    char_t           r_char;
    logic [NUM_DIGITS-1:0] r_an;
    logic            r_wrap, w_wrap, w_scan_tick, w_scroll_tick;

    // SCAN lasts SCAN_DIV-1 clocks; the preceding BLANK clock completes the slot
    tick_gen #(.DIV(SCAN_DIV - 1)) u_scan_tick (
        .clk(clk), .rst_n(rst_n), .i_en(i_enable && r_state == SCAN), .o_tick(w_scan_tick)
    );
    tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
        .clk(clk), .rst_n(rst_n), .i_en(i_enable && !i_pause), .o_tick(w_scroll_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (!i_enable)
            w_state_nxt = IDLE;
        else
            case (r_state)
                IDLE:    w_state_nxt = BLANK;
                BLANK:   w_state_nxt = SCAN;
                SCAN:    w_state_nxt = w_scan_tick ? BLANK : SCAN;
                default: w_state_nxt = IDLE;
            endcase
    end

    assign w_sum     = IW'(r_frame_off) + IW'(r_digit);
    assign w_rd_idx  = w_sum >= IW'(MSG_LEN) ? w_sum - IW'(MSG_LEN) : w_sum;
    assign w_wrap    = i_dir ? r_pos == '0 : r_pos == PW'(MSG_LEN - 1);
    assign w_pos_nxt = i_dir ? (w_wrap ? PW'(MSG_LEN - 1) : r_pos - 1'b1)
                             : (w_wrap ? '0 : r_pos + 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_digit     <= '0;
            r_frame_off <= '0;
            r_pos       <= '0;
            r_wrap      <= 1'b0;
            r_an        <= '1;
            r_char      <= CHAR_DASH;
            for (int i = 0; i < MSG_LEN; i++) r_buf[i] <= CHAR_DASH;
        end else begin
            r_state <= w_state_nxt;
            r_an    <= r_state == SCAN ? ~(NUM_DIGITS'(1) << r_digit) : '1;
            r_char  <= r_buf[w_rd_idx[PW-1:0]];
            r_wrap  <= w_scroll_tick && w_wrap;
            if (w_scroll_tick)
                r_pos <= w_pos_nxt;
            // offset is latched only at frame boundaries so one frame never mixes offsets
            if (w_scan_tick) begin
                r_digit <= r_digit == DW'(NUM_DIGITS - 1) ? '0 : r_digit + 1'b1;
                if (r_digit == DW'(NUM_DIGITS - 1))
                    r_frame_off <= r_pos;
            end
            if (i_msg_wr_en && {1'b0, i_msg_wr_addr} < 5'(MSG_LEN))
                r_buf[i_msg_wr_addr[PW-1:0]] <= i_msg_wr_data;
        end
    end

    assign o_char_code  = r_char;
    assign o_an         = r_an;
    assign o_scroll_pos = r_pos;
    assign o_wrap_pulse = r_wrap;
endmodule
